mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage, directly downstream of the EX stage. It consumes the ALU result as the effective address and the forwarded RT value as store data. It owns a synchronous byte-enabled data RAM and performs byte, halfword and word loads and stores with sign or zero extension. It registers the write-back bundle (MEM/WB) for the WB stage and provides a read-only debug port for the debug unit.

Parameters:
NB_REG, 32, data and address width
NB_ADDR, 5, register-file address width
NB_DADDR, 8, data RAM word-address width (depth = 2^NB_DADDR words)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_stall  in  1  hold stage; blocks RAM write and freezes MEM/WB registers
i_alu_result  in  NB_REG  effective address, or ALU value for non-memory ops
i_store_data  in  NB_REG  store data (forwarded RT from EX)
i_write_reg  in  NB_ADDR  destination register from EX
i_reg_write  in  1  instruction writes the register file
i_mem_to_reg  in  1  WB value comes from the load path
i_mem_read  in  1  load
i_mem_write  in  1  store
i_mem_width  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
i_load_unsigned  in  1  zero-extend loads (LBU/LHU)
i_dbg_addr  in  NB_DADDR  debug word address
o_wb_data  out  NB_REG  registered write-back value
o_write_reg  out  NB_ADDR  registered destination register
o_reg_write  out  1  registered register-file write enable
o_misaligned  out  1  registered one-cycle flag for a misaligned access
o_dbg_data  out  NB_REG  debug read data

Behaviour:
- Reset (asynchronous, active-high): o_wb_data, o_write_reg, o_reg_write, o_misaligned and o_dbg_data go to 0. Reset does not touch RAM contents; RAM is zero-initialised at configuration.
- Addressing:
  - Word index = i_alu_result[NB_DADDR+1:2]. Higher bits are ignored, so addresses wrap modulo the depth.
  - Byte offset = i_alu_result[1:0]. Byte lanes are little-endian: offset 0 is bits [7:0].
- Alignment:
  - A halfword access with offset[0]=1 is misaligned.
  - A word access with offset != 0 is misaligned.
  - A misaligned store writes nothing.
  - A misaligned load returns 0.
  - Both cases set o_misaligned for one cycle, with the same timing as o_wb_data.
- Stores:
  - Write occurs at the rising edge where i_mem_write=1, i_stall=0 and the access is aligned.
  - Byte enables: byte = one lane at offset; half = lanes {offset+1, offset}; word = all four.
  - Store data is replicated to lanes: byte = i_store_data[7:0] in every lane; half = [15:0] in both halves.
- Loads:
  - The RAM reads synchronously at the same edge.
  - Lane select and extension use the registered offset, width and unsigned flag, so o_wb_data is valid one cycle after the inputs are presented.
  - Load-to-use latency: 1 cycle.
- Write-back:
  - o_wb_data = extended load data when the registered mem_to_reg=1; otherwise the registered i_alu_result.
  - o_write_reg and o_reg_write are registered copies of their inputs.
- Stall: while i_stall=1, the MEM/WB registers hold their values, no RAM write occurs, and the held load data stays stable. Stall does not affect the debug port.
- Read and write asserted together: the write is performed, and the load returns the pre-write word (read-first).
- Store then load to the same word on consecutive cycles: the load sees the new data.
- Debug port: synchronous, 1-cycle latency, independent of stall. It is read-first with respect to a same-edge store.
- Non-memory instructions (i_mem_read=0, i_mem_write=0) pass i_alu_result through with 1-cycle latency.

Decomposition:
- Package mem_pkg holds:
  - width encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11
  - function for byte-enable generation
  - function for load extraction and extension
- One sub-module, data_ram: 2^NB_DADDR x NB_REG, 4 byte-write enables, one read/write port plus one read-only debug port, both synchronous and read-first.

Test Plan:
- SW 0xDEADBEEF at addr 0x10, then LW 0x10 -> o_wb_data=0xDEADBEEF one cycle after the load; o_dbg_data at word 4 = 0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF: LB at 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 at 0x11 over 0xDEADBEEF -> word reads 0xDEAD55EF; SH 0x1234 at 0x12 -> 0x123455EF.
- LW at 0x11 and SH at 0x13 -> o_misaligned=1 for one cycle, o_wb_data=0, RAM unchanged.
- i_stall=1 with i_mem_write=1 for 3 cycles -> no RAM change, outputs hold prior values; deassert -> write occurs at the next edge.
- Assert i_rst mid-load -> all outputs 0 immediately (asynchronous); RAM contents preserved, verified through the debug port.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-width encodings
// and the byte-lane helpers used for stores and loads.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;  // 2'b10 is reserved and handled as a word

  // Halfwords need an even offset; words (and the reserved code) need offset 0.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return offset[0];
      default:  return (offset != 2'b00);
    endcase
  endfunction

  // Little-endian byte-lane enables for an aligned access.
  function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      MEM_BYTE: return 4'b0001 << offset;
      MEM_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the enables alone pick the target bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] data);
    case (width)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

  // Pick the addressed byte/halfword out of a RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] offset, input logic is_unsigned);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    case (offset)
      2'd0:    v_byte = word[7:0];
      2'd1:    v_byte = word[15:8];
      2'd2:    v_byte = word[23:16];
      default: v_byte = word[31:24];
    endcase
    v_half = offset[1] ? word[31:16] : word[15:0];
    case (width)
      MEM_BYTE: return is_unsigned ? {24'd0, v_byte} : {{24{v_byte[7]}}, v_byte};
      MEM_HALF: return is_unsigned ? {16'd0, v_half} : {{16{v_half[15]}}, v_half};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-writable synchronous data RAM with one read/write port and one
// read-only debug port. Both read ports are read-first.
module data_ram #(
  parameter int NB_DATA  = 32,
  parameter int NB_DADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rd_en,
  input  logic [NB_DADDR-1:0] i_addr,
  input  logic [3:0]          i_wbe,
  input  logic [NB_DATA-1:0]  i_wdata,
  output logic [NB_DATA-1:0]  o_rdata,
  input  logic [NB_DADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]  o_dbg_data
);

  logic [NB_DATA-1:0] r_mem [2**NB_DADDR];

  // Byte-lane writes into the array.
  // NOTE: the array has no reset so it maps onto block RAM; only the read registers reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wbe[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  // Main-port read register; holds while the stage is stalled.
  // NOTE: non-blocking reads sample the array before this edge's write lands, giving read-first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        o_rdata <= '0;
    else if (i_rd_en) o_rdata <= r_mem[i_addr];
  end

  // Debug read register; free-running, unaffected by stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_dbg_data <= '0;
    else       o_dbg_data <= r_mem[i_dbg_addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data RAM from the EX results and forms the
// registered MEM/WB bundle, selecting between load data and the ALU value.
module mem_stage
  import mem_pkg::*;
#(
  parameter int NB_REG   = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_DADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stall,
  input  logic [NB_REG-1:0]   i_alu_result,
  input  logic [NB_REG-1:0]   i_store_data,
  input  logic [NB_ADDR-1:0]  i_write_reg,
  input  logic                i_reg_write,
  input  logic                i_mem_to_reg,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [1:0]          i_mem_width,
  input  logic                i_load_unsigned,
  input  logic [NB_DADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]   o_wb_data,
  output logic [NB_ADDR-1:0]  o_write_reg,
  output logic                o_reg_write,
  output logic                o_misaligned,
  output logic [NB_REG-1:0]   o_dbg_data
);

  logic [1:0]          w_offset;
  logic [NB_DADDR-1:0] w_word_addr;
  logic                w_misaligned;
  logic [3:0]          w_wbe;
  logic [NB_REG-1:0]   w_wdata;
  logic [NB_REG-1:0]   w_ram_rdata;
  logic                w_unused_addr_bits;

  logic [NB_REG-1:0]   r_alu_result;
  logic [NB_ADDR-1:0]  r_write_reg;
  logic                r_reg_write;
  logic                r_mem_to_reg;
  logic [1:0]          r_width;
  logic [1:0]          r_offset;
  logic                r_unsigned;
  logic                r_misaligned;

  // Upper address bits are dropped so accesses wrap modulo the RAM depth.
  assign w_offset           = i_alu_result[1:0];
  assign w_word_addr        = i_alu_result[NB_DADDR+1:2];
  assign w_unused_addr_bits = ^i_alu_result[NB_REG-1:NB_DADDR+2];

  // Only real memory operations can be misaligned; misaligned stores write nothing.
  assign w_misaligned = (i_mem_read | i_mem_write) & is_misaligned(i_mem_width, w_offset);
  assign w_wbe        = (i_mem_write && !i_stall && !w_misaligned)
                        ? byte_enables(i_mem_width, w_offset) : 4'b0000;
  assign w_wdata      = store_lanes(i_mem_width, i_store_data);

  data_ram #(
    .NB_DATA  (NB_REG),
    .NB_DADDR (NB_DADDR)
  ) u_data_ram (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_en    (!i_stall),
    .i_addr     (w_word_addr),
    .i_wbe      (w_wbe),
    .i_wdata    (w_wdata),
    .o_rdata    (w_ram_rdata),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // MEM/WB pipeline register; frozen while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_width      <= MEM_WORD;
      r_offset     <= 2'b00;
      r_unsigned   <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (!i_stall) begin
      r_alu_result <= i_alu_result;
      r_write_reg  <= i_write_reg;
      r_reg_write  <= i_reg_write;
      r_mem_to_reg <= i_mem_to_reg;
      r_width      <= i_mem_width;
      r_offset     <= w_offset;
      r_unsigned   <= i_load_unsigned;
      r_misaligned <= w_misaligned;
    end
  end

  // Write-back select: extracted load data (zero when misaligned) or the ALU value.
  always_comb begin
    o_wb_data = r_alu_result;
    if (r_mem_to_reg) begin
      o_wb_data = r_misaligned ? '0 : load_extract(w_ram_rdata, r_width, r_offset, r_unsigned);
    end
  end

  assign o_write_reg  = r_write_reg;
  assign o_reg_write  = r_reg_write;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_stall;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_write_reg;
  logic        i_reg_write;
  logic        i_mem_to_reg;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_width;
  logic        i_load_unsigned;
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_wb_data;
  logic [4:0]  o_write_reg;
  logic        o_reg_write;
  logic        o_misaligned;
  logic [31:0] o_dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_stall         (i_stall),
    .i_alu_result    (i_alu_result),
    .i_store_data    (i_store_data),
    .i_write_reg     (i_write_reg),
    .i_reg_write     (i_reg_write),
    .i_mem_to_reg    (i_mem_to_reg),
    .i_mem_read      (i_mem_read),
    .i_mem_write     (i_mem_write),
    .i_mem_width     (i_mem_width),
    .i_load_unsigned (i_load_unsigned),
    .i_dbg_addr      (i_dbg_addr),
    .o_wb_data       (o_wb_data),
    .o_write_reg     (o_write_reg),
    .o_reg_write     (o_reg_write),
    .o_misaligned    (o_misaligned),
    .o_dbg_data      (o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic nop();
    i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0; i_reg_write = 0;
    i_mem_width = 2'b11; i_load_unsigned = 0; i_alu_result = 0; i_store_data = 0; i_write_reg = 0;
  endtask

  task automatic store(input logic [1:0] w, input logic [31:0] addr, input logic [31:0] data);
    nop();
    i_mem_write = 1; i_mem_width = w; i_alu_result = addr; i_store_data = data;
  endtask

  task automatic load(input logic [1:0] w, input logic uns, input logic [31:0] addr, input logic [4:0] rd);
    nop();
    i_mem_read = 1; i_mem_to_reg = 1; i_reg_write = 1; i_mem_width = w;
    i_load_unsigned = uns; i_alu_result = addr; i_write_reg = rd;
  endtask

  task automatic test_reset();
    i_rst = 1; i_stall = 0; i_dbg_addr = 8'd4; nop();
    #12;
    n_checks++; if (o_wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data got=%h exp=0", o_wb_data); end
    n_checks++; if (o_write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg got=%h exp=0", o_write_reg); end
    n_checks++; if (o_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got=%b exp=0", o_reg_write); end
    n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got=%b exp=0", o_misaligned); end
    n_checks++; if (o_dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_data got=%h exp=0", o_dbg_data); end
    @(negedge i_clk); i_rst = 0;
    step();
  endtask

  task automatic test_word_store_load();
    store(2'b11, 32'h10, 32'hDEADBEEF); step();
    load(2'b11, 0, 32'h10, 5'd9); step();
    n_checks++; if (o_wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got=%h exp=deadbeef", o_wb_data); end
    n_checks++; if (o_write_reg !== 5'd9 || o_reg_write !== 1'b1) begin n_fail++; $display("FAIL lw_dest got=%h/%b exp=09/1", o_write_reg, o_reg_write); end
    n_checks++; if (o_dbg_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dbg_word4 got=%h exp=deadbeef", o_dbg_data); end
    n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned got=%b exp=0", o_misaligned); end
  endtask

  task automatic test_sub_word_loads();
    load(2'b00, 0, 32'h13, 5'd1); step();
    n_checks++; if (o_wb_data !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb got=%h exp=ffffffde", o_wb_data); end
    load(2'b00, 1, 32'h13, 5'd1); step();
    n_checks++; if (o_wb_data !== 32'h000000DE) begin n_fail++; $display("FAIL lbu got=%h exp=000000de", o_wb_data); end
    load(2'b01, 0, 32'h12, 5'd1); step();
    n_checks++; if (o_wb_data !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh got=%h exp=ffffdead", o_wb_data); end
    load(2'b01, 1, 32'h10, 5'd1); step();
    n_checks++; if (o_wb_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu got=%h exp=0000beef", o_wb_data); end
    load(2'b00, 0, 32'h10, 5'd1); step();
    n_checks++; if (o_wb_data !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_off0 got=%h exp=ffffffef", o_wb_data); end
  endtask

  task automatic test_sub_word_stores();
    store(2'b00, 32'h11, 32'hFFFFFF55); step();
    load(2'b11, 0, 32'h10, 5'd2); step();
    n_checks++; if (o_wb_data !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb got=%h exp=dead55ef", o_wb_data); end
    store(2'b01, 32'h12, 32'hFFFF1234); step();
    load(2'b11, 0, 32'h10, 5'd2); step();
    n_checks++; if (o_wb_data !== 32'h123455EF) begin n_fail++; $display("FAIL sh got=%h exp=123455ef", o_wb_data); end
    // Read and write together: load and debug port both see the old word.
    load(2'b11, 0, 32'h10, 5'd2); i_mem_write = 1; i_store_data = 32'hCAFEF00D; step();
    n_checks++; if (o_wb_data !== 32'h123455EF) begin n_fail++; $display("FAIL rw_read_first got=%h exp=123455ef", o_wb_data); end
    n_checks++; if (o_dbg_data !== 32'h123455EF) begin n_fail++; $display("FAIL dbg_read_first got=%h exp=123455ef", o_dbg_data); end
    load(2'b11, 0, 32'h10, 5'd2); step();
    n_checks++; if (o_wb_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rw_written got=%h exp=cafef00d", o_wb_data); end
  endtask

  task automatic test_passthrough();
    nop(); i_alu_result = 32'hA5A50001; i_reg_write = 1; i_write_reg = 5'd7; step();
    n_checks++; if (o_wb_data !== 32'hA5A50001) begin n_fail++; $display("FAIL pass_data got=%h exp=a5a50001", o_wb_data); end
    n_checks++; if (o_write_reg !== 5'd7 || o_reg_write !== 1'b1) begin n_fail++; $display("FAIL pass_dest got=%h/%b exp=07/1", o_write_reg, o_reg_write); end
    // An unaligned ALU value is not a memory access.
    nop(); i_alu_result = 32'h00000013; step();
    n_checks++; if (o_misaligned !== 1'b0 || o_reg_write !== 1'b0) begin n_fail++; $display("FAIL pass_unaligned got=%b/%b exp=0/0", o_misaligned, o_reg_write); end
  endtask

  task automatic test_misaligned();
    load(2'b11, 0, 32'h11, 5'd3); step();
    n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL lw_mis_flag got=%b exp=1", o_misaligned); end
    n_checks++; if (o_wb_data !== 32'h0) begin n_fail++; $display("FAIL lw_mis_data got=%h exp=0", o_wb_data); end
    nop(); step();
    n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got=%b exp=0", o_misaligned); end
    store(2'b01, 32'h13, 32'h0000FFFF); step();
    n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL sh_mis_flag got=%b exp=1", o_misaligned); end
    load(2'b11, 0, 32'h10, 5'd3); step();
    n_checks++; if (o_wb_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sh_mis_ram got=%h exp=cafef00d", o_wb_data); end
    n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL sh_mis_clear got=%b exp=0", o_misaligned); end
  endtask

  task automatic test_stall();
    load(2'b11, 0, 32'h10, 5'd4); step();
    store(2'b11, 32'h10, 32'h0BADF00D); i_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (o_wb_data !== 32'hCAFEF00D || o_write_reg !== 5'd4 || o_reg_write !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=cafef00d/04/1", c, o_wb_data, o_write_reg, o_reg_write);
      end
      n_checks++; if (o_dbg_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stall_no_write[%0d] got=%h exp=cafef00d", c, o_dbg_data); end
    end
    i_stall = 0; step();
    n_checks++; if (o_wb_data !== 32'h10 || o_reg_write !== 1'b0) begin n_fail++; $display("FAIL unstall_wb got=%h/%b exp=00000010/0", o_wb_data, o_reg_write); end
    // Address 0x410 wraps to word 4.
    load(2'b11, 0, 32'h410, 5'd4); step();
    n_checks++; if (o_wb_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL unstall_write got=%h exp=0badf00d", o_wb_data); end
  endtask

  task automatic test_reset_mid_load();
    load(2'b11, 0, 32'h10, 5'd5); step();
    @(posedge i_clk); #3; i_rst = 1; #1;
    n_checks++; if (o_wb_data !== 32'h0 || o_write_reg !== 5'd0 || o_reg_write !== 1'b0 || o_misaligned !== 1'b0 || o_dbg_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got=%h/%h/%b/%b/%h exp=all zero", o_wb_data, o_write_reg, o_reg_write, o_misaligned, o_dbg_data);
    end
    @(negedge i_clk); i_rst = 0; nop(); i_dbg_addr = 8'd4; step();
    n_checks++; if (o_dbg_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL ram_kept got=%h exp=0badf00d", o_dbg_data); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_sub_word_loads();
    test_sub_word_stores();
    test_passthrough();
    test_misaligned();
    test_stall();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
